sram_arbiter: RTL and testbench

//  Shares the board's 16-bit asynchronous SRAM (18-bit word address, active-low CS/WE/OE/UB/LB) between two

---
 rtl/sram_arbiter_pkg.sv | 24 ++
 rtl/sram_rr_arbiter.sv | 37 +++
 rtl/sram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared FSM encodings, port ids and wait-count helper for the SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } sram_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Wait counter is 4 bits; out-of-range parameters saturate instead of wrapping.
  function automatic logic [3:0] wait_load(input int cycles);
    if (cycles > 15) return 4'd15;
    if (cycles < 0) return 4'd0;
    return cycles[3:0];
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: 2-way grant, round-robin or fixed priority, plus the last-grant register.
// Latency: grant is combinational from requests; last_grant updates on the accept edge only.
// Backpressure: a request with no accept leaves the rotation untouched.
// Ports: i_clk/i_rst_n, i_req {p1,p0}, i_accept (command taken this edge), o_grant (winning port id).
module sram_rr_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = PORT0;
    if (i_req == 2'b10) begin
      o_grant = PORT1;
    end else if (i_req == 2'b11) begin
      o_grant = (FIXED_PRIO != 0) ? PORT0 : ~r_last_grant;
    end
  end

  // Reset value PORT1 lets port 0 win the first contest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_grant <= PORT1;
    end else if (i_accept) begin
      r_last_grant <= o_grant;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit async SRAM between two requesters and sequences its pin timing.
// Latency: read accept edge -> rsp sampled RD_WAIT+2 edges later; write occupies WR_WAIT+3 busy cycles + 1 idle.
// Backpressure: cmd_ready only in IDLE for the granted, valid port; responses have no backpressure.
// Ports: p0/p1 cmd (valid/ready/write/addr/wdata/mask), p0/p1 rsp (valid/rdata), io_busy,
//   io_sram_* registered address, pad data/enable and active-low cs/we/oe/ub/lb strobes.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int RD_WAIT    = 1,
  parameter int WR_WAIT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  io_mainClk,
  input  logic                  io_asyncReset_n,
  input  logic                  p0_cmd_valid,
  output logic                  p0_cmd_ready,
  input  logic                  p0_cmd_write,
  input  logic [ADDR_WIDTH-1:0] p0_cmd_addr,
  input  logic [15:0]           p0_cmd_wdata,
  input  logic [1:0]            p0_cmd_mask,
  output logic                  p0_rsp_valid,
  output logic [15:0]           p0_rsp_rdata,
  input  logic                  p1_cmd_valid,
  output logic                  p1_cmd_ready,
  input  logic                  p1_cmd_write,
  input  logic [ADDR_WIDTH-1:0] p1_cmd_addr,
  input  logic [15:0]           p1_cmd_wdata,
  input  logic [1:0]            p1_cmd_mask,
  output logic                  p1_rsp_valid,
  output logic [15:0]           p1_rsp_rdata,
  output logic                  io_busy,
  output logic [ADDR_WIDTH-1:0] io_sram_addr,
  output logic [15:0]           io_sram_dat_write,
  output logic                  io_sram_dat_writeEnable,
  input  logic [15:0]           io_sram_dat_read,
  output logic                  io_sram_cs,
  output logic                  io_sram_we,
  output logic                  io_sram_oe,
  output logic                  io_sram_ub,
  output logic                  io_sram_lb
);

  localparam logic [3:0] RD_LOAD = wait_load(RD_WAIT);
  localparam logic [3:0] WR_LOAD = wait_load(WR_WAIT);

  sram_state_e           r_state, w_next_state;
  logic [3:0]            r_wait, w_wait_nxt;
  logic                  r_owner;
  logic [1:0]            r_mask, w_mask_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_dat_write, r_rdata;
  logic [1:0]            r_rsp_vld;
  logic                  r_cs_n, r_we_n, r_oe_n, r_ub_n, r_lb_n, r_dat_oe;
  logic                  w_cs_n, w_we_n, w_oe_n, w_ub_n, w_lb_n, w_dat_oe;
  logic [1:0]            w_req;
  logic                  w_grant, w_idle, w_accept;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [15:0]           w_sel_wdata;
  logic [1:0]            w_sel_mask;

  assign w_req    = {p1_cmd_valid, p0_cmd_valid};
  // Ready is forced low while reset is asserted, not just after the state register clears.
  assign w_idle   = (r_state == ST_IDLE) && io_asyncReset_n;
  assign w_accept = w_idle && (|w_req);

  assign p0_cmd_ready = w_idle && (w_grant == PORT0) && p0_cmd_valid;
  assign p1_cmd_ready = w_idle && (w_grant == PORT1) && p1_cmd_valid;

  assign w_sel_write = (w_grant == PORT1) ? p1_cmd_write : p0_cmd_write;
  assign w_sel_addr  = (w_grant == PORT1) ? p1_cmd_addr  : p0_cmd_addr;
  assign w_sel_wdata = (w_grant == PORT1) ? p1_cmd_wdata : p0_cmd_wdata;
  assign w_sel_mask  = (w_grant == PORT1) ? p1_cmd_mask  : p0_cmd_mask;
  assign w_mask_nxt  = (w_accept && w_sel_write) ? w_sel_mask : r_mask;

  sram_rr_arbiter #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .i_clk    (io_mainClk),
    .i_rst_n  (io_asyncReset_n),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_grant  (w_grant)
  );

  always_comb begin
    w_next_state = r_state;
    w_wait_nxt   = r_wait;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_sel_write) begin
            w_next_state = ST_WR_SETUP;
          end else begin
            w_next_state = ST_READ;
            w_wait_nxt   = RD_LOAD;
          end
        end
      end
      ST_READ: begin
        if (r_wait == 4'd0) w_next_state = ST_IDLE;
        else                w_wait_nxt   = r_wait - 4'd1;
      end
      ST_WR_SETUP: begin
        w_next_state = ST_WR_PULSE;
        w_wait_nxt   = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (r_wait == 4'd0) w_next_state = ST_WR_HOLD;
        else                w_wait_nxt   = r_wait - 4'd1;
      end
      ST_WR_HOLD: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Pins are decoded from the next state so the registered strobes line up with the state register.
  always_comb begin
    w_cs_n   = 1'b1;
    w_we_n   = 1'b1;
    w_oe_n   = 1'b1;
    w_ub_n   = 1'b1;
    w_lb_n   = 1'b1;
    w_dat_oe = 1'b0;
    case (w_next_state)
      ST_READ: begin
        w_cs_n = 1'b0;
        w_oe_n = 1'b0;
        w_ub_n = 1'b0;
        w_lb_n = 1'b0;
      end
      ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD: begin
        w_cs_n   = 1'b0;
        w_dat_oe = 1'b1;
        w_we_n   = (w_next_state != ST_WR_PULSE);
        {w_ub_n, w_lb_n} = ~w_mask_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge io_mainClk or negedge io_asyncReset_n) begin
    if (!io_asyncReset_n) begin
      r_state     <= ST_IDLE;
      r_wait      <= 4'd0;
      r_owner     <= PORT0;
      r_mask      <= 2'b00;
      r_addr      <= '0;
      r_dat_write <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_rsp_vld   <= 2'b00;
      r_cs_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_dat_oe    <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_wait   <= w_wait_nxt;
      r_mask   <= w_mask_nxt;
      r_cs_n   <= w_cs_n;
      r_we_n   <= w_we_n;
      r_oe_n   <= w_oe_n;
      r_ub_n   <= w_ub_n;
      r_lb_n   <= w_lb_n;
      r_dat_oe <= w_dat_oe;
      if (w_accept) begin
        r_owner <= w_grant;
        r_addr  <= w_sel_addr;
        if (w_sel_write) r_dat_write <= w_sel_wdata;
      end
      // Capture on the last READ edge; the strobe lands in the following IDLE cycle.
      r_rsp_vld <= 2'b00;
      if ((r_state == ST_READ) && (r_wait == 4'd0)) begin
        r_rdata   <= io_sram_dat_read;
        r_rsp_vld <= (r_owner == PORT1) ? 2'b10 : 2'b01;
      end
    end
  end

  assign io_busy                 = (r_state != ST_IDLE);
  assign io_sram_addr            = r_addr;
  assign io_sram_dat_write       = r_dat_write;
  assign io_sram_dat_writeEnable = r_dat_oe;
  assign io_sram_cs              = r_cs_n;
  assign io_sram_we              = r_we_n;
  assign io_sram_oe              = r_oe_n;
  assign io_sram_ub              = r_ub_n;
  assign io_sram_lb              = r_lb_n;
  assign p0_rsp_valid            = r_rsp_vld[0];
  assign p1_rsp_valid            = r_rsp_vld[1];
  assign p0_rsp_rdata            = r_rdata;
  assign p1_rsp_rdata            = r_rdata;

  // Pad contention and strobe ordering guards.
  a_no_oe_while_driving: assert property (@(posedge io_mainClk) disable iff (!io_asyncReset_n)
    !(!r_oe_n && r_dat_oe));
  a_no_we_while_oe: assert property (@(posedge io_mainClk) disable iff (!io_asyncReset_n)
    !(!r_we_n && !r_oe_n));

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: four arbiter instances (different wait/priority settings) against a behavioural SRAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arbiter;

  // Per-instance settings, nibble k = instance k: RD {1,0,15,3}, WR {1,0,3,15}, FIXED_PRIO {0,1,0,1}.
  localparam logic [15:0] RDW_P = 16'h3F01;
  localparam logic [15:0] WRW_P = 16'hF301;
  localparam logic [3:0]  FP_P  = 4'b1010;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        p0_v [4], p0_r [4], p0_w [4], p0_rv [4];
  logic        p1_v [4], p1_r [4], p1_w [4], p1_rv [4];
  logic [17:0] p0_a [4], p1_a [4], saddr [4];
  logic [15:0] p0_d [4], p1_d [4], p0_rd [4], p1_rd [4], sdw [4], sdr [4];
  logic [1:0]  p0_m [4], p1_m [4];
  logic        busy [4], cs [4], we [4], oe [4], ub [4], lb [4], doe [4];

  logic [15:0] mem [4][256];
  int oe_run [4] = '{0, 0, 0, 0};
  int we_run [4] = '{0, 0, 0, 0};
  int oe_w [4]   = '{0, 0, 0, 0};
  int we_w [4]   = '{0, 0, 0, 0};
  int p0_cnt [4] = '{0, 0, 0, 0};
  int p1_cnt [4] = '{0, 0, 0, 0};
  int viol [4]   = '{0, 0, 0, 0};

  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sram_arbiter #(
      .ADDR_WIDTH (18),
      .RD_WAIT    (int'(RDW_P[g*4 +: 4])),
      .WR_WAIT    (int'(WRW_P[g*4 +: 4])),
      .FIXED_PRIO (int'(FP_P[g]))
    ) u_dut (
      .io_mainClk              (clk),
      .io_asyncReset_n         (rst_n),
      .p0_cmd_valid            (p0_v[g]),
      .p0_cmd_ready            (p0_r[g]),
      .p0_cmd_write            (p0_w[g]),
      .p0_cmd_addr             (p0_a[g]),
      .p0_cmd_wdata            (p0_d[g]),
      .p0_cmd_mask             (p0_m[g]),
      .p0_rsp_valid            (p0_rv[g]),
      .p0_rsp_rdata            (p0_rd[g]),
      .p1_cmd_valid            (p1_v[g]),
      .p1_cmd_ready            (p1_r[g]),
      .p1_cmd_write            (p1_w[g]),
      .p1_cmd_addr             (p1_a[g]),
      .p1_cmd_wdata            (p1_d[g]),
      .p1_cmd_mask             (p1_m[g]),
      .p1_rsp_valid            (p1_rv[g]),
      .p1_rsp_rdata            (p1_rd[g]),
      .io_busy                 (busy[g]),
      .io_sram_addr            (saddr[g]),
      .io_sram_dat_write       (sdw[g]),
      .io_sram_dat_writeEnable (doe[g]),
      .io_sram_dat_read        (sdr[g]),
      .io_sram_cs              (cs[g]),
      .io_sram_we              (we[g]),
      .io_sram_oe              (oe[g]),
      .io_sram_ub              (ub[g]),
      .io_sram_lb              (lb[g])
    );
  end

  // Behavioural async SRAM (low 8 address bits) plus strobe-width / response monitors.
  always_comb begin
    for (int k = 0; k < 4; k++)
      sdr[k] = (!cs[k] && !oe[k]) ? mem[k][saddr[k][7:0]] : 16'hDEAD;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!cs[k] && !we[k]) begin
        if (!ub[k]) mem[k][saddr[k][7:0]][15:8] <= sdw[k][15:8];
        if (!lb[k]) mem[k][saddr[k][7:0]][7:0]  <= sdw[k][7:0];
      end
      if (!oe[k]) oe_run[k] <= oe_run[k] + 1;
      else if (oe_run[k] != 0) begin oe_w[k] <= oe_run[k]; oe_run[k] <= 0; end
      if (!we[k]) we_run[k] <= we_run[k] + 1;
      else if (we_run[k] != 0) begin we_w[k] <= we_run[k]; we_run[k] <= 0; end
      if (p0_rv[k]) p0_cnt[k] <= p0_cnt[k] + 1;
      if (p1_rv[k]) p1_cnt[k] <= p1_cnt[k] + 1;
      if ((!oe[k] && doe[k]) || (!we[k] && !oe[k])) viol[k] <= viol[k] + 1;
    end
  end

  function automatic int rdw(input int k);
    return int'(RDW_P[k*4 +: 4]);
  endfunction

  function automatic int wrw(input int k);
    return int'(WRW_P[k*4 +: 4]);
  endfunction

  // Drives one command and returns #1 after the accepting edge.
  task automatic issue(input int k, input logic port, input logic wr, input logic [17:0] a,
                       input logic [15:0] d, input logic [1:0] m);
    logic got;
    int n;
    @(negedge clk);
    if (port) begin p1_w[k] = wr; p1_a[k] = a; p1_d[k] = d; p1_m[k] = m; p1_v[k] = 1'b1; end
    else      begin p0_w[k] = wr; p0_a[k] = a; p0_d[k] = d; p0_m[k] = m; p0_v[k] = 1'b1; end
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      #1;
      got = port ? p1_r[k] : p0_r[k];
      @(posedge clk);
      n++;
    end
    #1;
    if (port) p1_v[k] = 1'b0; else p0_v[k] = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL issue_timeout inst=%0d port=%0d got=no_ready want=ready", k, port);
    end
  endtask

  task automatic wait_idle(input int k, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (busy[k] && cyc < 400) begin cyc++; @(negedge clk); end
    if (busy[k]) begin
      total++; bad++;
      $display("FAIL idle_timeout inst=%0d got=busy want=idle", k);
    end
  endtask

  task automatic do_read(input int k, input logic port, input logic [17:0] a,
                         output logic [15:0] data, output int lat);
    logic got;
    issue(k, port, 1'b0, a, 16'h0000, 2'b00);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      got = port ? p1_rv[k] : p0_rv[k];
    end
    data = port ? p1_rd[k] : p0_rd[k];
    if (!got) begin
      lat = -1;
      total++; bad++;
      $display("FAIL rsp_timeout inst=%0d port=%0d got=no_rsp want=rsp", k, port);
    end
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin p0_v[k] = 1'b1; p1_v[k] = 1'b1; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      obs = {cs[k], we[k], oe[k], ub[k], lb[k], doe[k], busy[k], p0_r[k], p1_r[k]};
      total++;
      if (obs !== 9'b111110000) begin
        bad++;
        $display("FAIL reset_pins inst=%0d got=%b want=%b", k, obs, 9'b111110000);
      end
    end
    for (int k = 0; k < 4; k++) begin p0_v[k] = 1'b0; p1_v[k] = 1'b0; end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({busy[k], cs[k], doe[k]} !== 3'b010 || (p0_cnt[k] + p1_cnt[k]) != 0 ||
          saddr[k] !== 18'h0 || sdw[k] !== 16'h0) begin
        bad++;
        $display("FAIL reset_release inst=%0d got busy/cs/oe=%b rsp=%0d addr=%h dat=%h want 010 0 0 0",
                 k, {busy[k], cs[k], doe[k]}, p0_cnt[k] + p1_cnt[k], saddr[k], sdw[k]);
      end
    end
  endtask

  task automatic test_write_read();
    int cyc, lat, b0, b1;
    logic [15:0] d;
    b0 = p0_cnt[0]; b1 = p1_cnt[0];
    issue(0, 1'b0, 1'b1, 18'h00012, 16'hA5C3, 2'b11);
    wait_idle(0, cyc);
    total++;
    if (cyc != 4) begin bad++; $display("FAIL wr_busy_cycles got=%0d want=4", cyc); end
    total++;
    if (mem[0][8'h12] !== 16'hA5C3) begin
      bad++; $display("FAIL wr_mem got=%h want=a5c3", mem[0][8'h12]);
    end
    do_read(0, 1'b0, 18'h00012, d, lat);
    total++;
    if (lat != 3) begin bad++; $display("FAIL rd_latency got=%0d want=3", lat); end
    total++;
    if (d !== 16'hA5C3) begin bad++; $display("FAIL rd_data got=%h want=a5c3", d); end
    repeat (4) @(negedge clk);
    total++;
    if (p0_cnt[0] - b0 != 1 || p1_cnt[0] - b1 != 0) begin
      bad++;
      $display("FAIL rsp_routing got p0=%0d p1=%0d want p0=1 p1=0", p0_cnt[0] - b0, p1_cnt[0] - b1);
    end
  endtask

  task automatic test_byte_mask();
    logic [15:0] wd [4] = '{16'hFFFF, 16'h1234, 16'hABCD, 16'h5678};
    logic [1:0]  wm [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
    logic [15:0] ex [4] = '{16'hFFFF, 16'hFF34, 16'hFF34, 16'h5634};
    logic [15:0] d;
    int cyc, lat;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 1'b1, 18'h00020, wd[i], wm[i]);
      wait_idle(0, cyc);
      do_read(0, 1'b0, 18'h00020, d, lat);
      total++;
      if (d !== ex[i]) begin
        bad++; $display("FAIL byte_mask step=%0d mask=%b got=%h want=%h", i, wm[i], d, ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc, b0, b1;
    issue(0, 1'b0, 1'b1, 18'h00060, 16'h2222, 2'b11);
    wait_idle(0, cyc);
    b0 = p0_cnt[0]; b1 = p1_cnt[0];
    issue(0, 1'b0, 1'b1, 18'h00060, 16'h1111, 2'b11);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (we[0] !== 1'b0) begin bad++; $display("FAIL pulse_entry got we=%b want=0", we[0]); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({we[0], cs[0], doe[0], busy[0]} !== 4'b1100) begin
      bad++; $display("FAIL async_abort got we/cs/oe/busy=%b want=1100", {we[0], cs[0], doe[0], busy[0]});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (p0_cnt[0] != b0 || p1_cnt[0] != b1 || busy[0] !== 1'b0 || mem[0][8'h60] !== 16'h2222) begin
      bad++;
      $display("FAIL abort_after got rsp=%0d busy=%b mem=%h want rsp=0 busy=0 mem=2222",
               p0_cnt[0] - b0 + p1_cnt[0] - b1, busy[0], mem[0][8'h60]);
    end
  endtask

  task automatic run_contention(input int k, output logic [6:0] order, output int n0, output int n1);
    int g, n, b0, b1, cyc;
    b0 = p0_cnt[k]; b1 = p1_cnt[k];
    order = '0; g = 0; n = 0;
    @(negedge clk);
    p0_w[k] = 1'b0; p0_a[k] = 18'h40; p0_v[k] = 1'b1;
    p1_w[k] = 1'b0; p1_a[k] = 18'h41; p1_v[k] = 1'b1;
    while (g < 7 && n < 500) begin
      #1;
      if (p0_r[k] || p1_r[k]) begin order[g] = p1_r[k]; g++; end
      @(posedge clk);
      n++;
      #1;
      if (g == 6) p0_v[k] = 1'b0;
      @(negedge clk);
    end
    p0_v[k] = 1'b0; p1_v[k] = 1'b0;
    if (g < 7) begin
      total++; bad++;
      $display("FAIL contention_timeout inst=%0d got=%0d grants want=7", k, g);
    end
    wait_idle(k, cyc);
    repeat (3) @(negedge clk);
    n0 = p0_cnt[k] - b0;
    n1 = p1_cnt[k] - b1;
  endtask

  task automatic test_contention();
    logic [6:0] ord;
    int n0, n1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // Round-robin: 0,1,0,1,0,1 then port 1 alone (bit i = port of grant i).
    run_contention(0, ord, n0, n1);
    total++;
    if (ord !== 7'b1101010) begin bad++; $display("FAIL rr_order got=%b want=1101010", ord); end
    total++;
    if (n0 != 3 || n1 != 4) begin bad++; $display("FAIL rr_rsp got p0=%0d p1=%0d want 3 4", n0, n1); end
    // Fixed priority: six port-0 grants, port 1 only once port 0 lets go.
    run_contention(1, ord, n0, n1);
    total++;
    if (ord !== 7'b1000000) begin bad++; $display("FAIL fp_order got=%b want=1000000", ord); end
    total++;
    if (n0 != 6 || n1 != 1) begin bad++; $display("FAIL fp_rsp got p0=%0d p1=%0d want 6 1", n0, n1); end
  endtask

  task automatic test_sweep();
    logic [15:0] sd [4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hFEDC};
    logic [15:0] d;
    int cyc, lat;
    for (int k = 0; k < 4; k++) begin
      issue(k, 1'b1, 1'b1, 18'h00080, sd[k], 2'b11);
      wait_idle(k, cyc);
      total++;
      if (cyc != wrw(k) + 3) begin
        bad++; $display("FAIL sweep_wr_busy inst=%0d got=%0d want=%0d", k, cyc, wrw(k) + 3);
      end
      total++;
      if (we_w[k] != wrw(k) + 1) begin
        bad++; $display("FAIL sweep_we_width inst=%0d got=%0d want=%0d", k, we_w[k], wrw(k) + 1);
      end
      do_read(k, 1'b1, 18'h00080, d, lat);
      total++;
      if (lat != rdw(k) + 2 || d !== sd[k]) begin
        bad++;
        $display("FAIL sweep_read inst=%0d got lat=%0d data=%h want lat=%0d data=%h",
                 k, lat, d, rdw(k) + 2, sd[k]);
      end
      @(posedge clk);
      #1;
      total++;
      if (oe_w[k] != rdw(k) + 1) begin
        bad++; $display("FAIL sweep_oe_width inst=%0d got=%0d want=%0d", k, oe_w[k], rdw(k) + 1);
      end
      total++;
      if (viol[k] != 0) begin
        bad++; $display("FAIL strobe_order inst=%0d got=%0d violations want=0", k, viol[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      p0_v[k] = 1'b0; p0_w[k] = 1'b0; p0_a[k] = '0; p0_d[k] = '0; p0_m[k] = '0;
      p1_v[k] = 1'b0; p1_w[k] = 1'b0; p1_a[k] = '0; p1_d[k] = '0; p1_m[k] = '0;
    end
    test_reset();
    test_write_read();
    test_byte_mask();
    test_reset_mid_write();
    test_contention();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
